// File: rtl/spi_custom_master.sv
// rtl/spi_custom_master.sv - custom 3-wire SPI master: framed MOSI transmitter and start-bit MISO receiver
module spi_custom_master #(
  parameter int KEY_LENGTH = 32
) (
  input  logic                  SCLK,
  input  logic                  rst,
  input  logic [KEY_LENGTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_frame_start,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic [KEY_LENGTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_busy
);

  localparam int CW = $clog2(KEY_LENGTH + 1);
  localparam int RW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(KEY_LENGTH);
  localparam logic [RW-1:0] LAST_RX  = RW'(KEY_LENGTH - 1);

  typedef enum logic {
    IDLE,
    RECV
  } rx_state_t;

  logic [CW-1:0]         bit_cnt;
  logic                  hold_full;
  logic [KEY_LENGTH-1:0] hold;
  logic [KEY_LENGTH:0]   tx_shift;
  logic                  boundary;
  logic                  accept;

  rx_state_t             rx_state;
  rx_state_t             rx_state_next;
  logic [RW-1:0]         rx_cnt;
  logic [KEY_LENGTH-2:0] rx_shift;
  logic                  rx_start;
  logic                  rx_shift_en;
  logic                  rx_done;

  assign tx_ready = !hold_full;
  assign boundary = (bit_cnt == LAST_BIT);
  assign accept   = tx_valid && !hold_full;

  // Frame counter runs in lockstep with the slave's counter from reset release.
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (boundary) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // A word accepted on the boundary edge waits in hold; it never bypasses into the frame starting now.
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      hold_full      <= 1'b0;
      hold           <= '0;
      tx_shift       <= '0;
      tx_frame_start <= 1'b0;
    end else begin
      tx_frame_start <= boundary && hold_full;
      if (boundary) begin
        tx_shift <= hold_full ? {1'b1, hold} : '0;
      end
      if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (boundary) begin
        hold_full <= 1'b0;
      end
    end
  end

  always_ff @(negedge SCLK or posedge rst) begin
    if (rst) begin
      MOSI <= 1'b0;
    end else begin
      MOSI <= tx_shift[bit_cnt];
    end
  end

  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      rx_state <= IDLE;
    end else begin
      rx_state <= rx_state_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_start      = 1'b0;
    rx_shift_en   = 1'b0;
    rx_done       = 1'b0;
    case (rx_state)
      IDLE: begin
        if (MISO) begin
          rx_state_next = RECV;
          rx_start      = 1'b1;
        end
      end
      RECV: begin
        rx_shift_en = 1'b1;
        if (rx_cnt == LAST_RX) begin
          rx_done       = 1'b1;
          rx_state_next = IDLE;
        end
      end
      default: rx_state_next = IDLE;
    endcase
  end

  // LSB arrives first, so bits enter at the top and walk down.
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      rx_valid <= rx_done;
      if (rx_start) begin
        rx_cnt  <= '0;
        rx_busy <= 1'b1;
      end
      if (rx_shift_en) begin
        rx_shift <= {MISO, rx_shift[KEY_LENGTH-2:1]};
        rx_cnt   <= rx_cnt + RW'(1);
      end
      if (rx_done) begin
        rx_data <= {MISO, rx_shift};
        rx_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_custom_master.sv
// tb/tb_spi_custom_master.sv - directed vector bench for spi_custom_master with KEY_LENGTH=8
module tb_spi_custom_master;

  localparam int KL = 8;

  logic          SCLK = 1'b0;
  logic          rst = 1'b1;
  logic [KL-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          tx_frame_start;
  logic          MOSI;
  logic          MISO = 1'b0;
  logic [KL-1:0] rx_data;
  logic          rx_valid;
  logic          rx_busy;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  spi_custom_master #(.KEY_LENGTH(KL)) dut (
    .SCLK(SCLK),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_frame_start(tx_frame_start),
    .MOSI(MOSI),
    .MISO(MISO),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_busy(rx_busy)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    logic          tv;
    logic [KL-1:0] td;
    logic          miso;
    logic          ready;
    logic          fs;
    logic          mosi;
    logic          busy;
    logic          rv;
    logic [KL-1:0] rd;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic tv, logic [KL-1:0] td, logic miso, logic ready, logic fs,
                              logic mosi, logic busy, logic rv, logic [KL-1:0] rd);
    vec_t v;
    v.tv = tv; v.td = td; v.miso = miso; v.ready = ready; v.fs = fs;
    v.mosi = mosi; v.busy = busy; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1ns after the posedge; MOSI then still holds the bit the slave just took.
  task automatic step();
    @(posedge SCLK);
    #1;
    k++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " mosi"}, 16'(MOSI), 16'h0);
    chk({tag, " tx_ready"}, 16'(tx_ready), 16'h1);
    chk({tag, " frame_start"}, 16'(tx_frame_start), 16'h0);
    chk({tag, " rx_data"}, 16'(rx_data), 16'h0);
    chk({tag, " rx_valid"}, 16'(rx_valid), 16'h0);
    chk({tag, " rx_busy"}, 16'(rx_busy), 16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    MISO = 1'b0;
    @(posedge SCLK);
    @(posedge SCLK);
    #1;
    check_reset_outputs("reset");
    @(negedge SCLK);
    #1;
    rst = 1'b0;
    k = 0;
  endtask

  initial begin
    logic [8:0] w1;
    logic [8:0] w2;
    logic [7:0] slave_word;
    int fs_cnt;

    tbl[0]  = mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00);
    tbl[1]  = mk(1, 8'hA5, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[2]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[3]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[4]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[5]  = mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00);
    tbl[6]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00);
    tbl[7]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00);
    tbl[8]  = mk(0, 8'h00, 1, 1, 1, 0, 1, 0, 8'h00);
    tbl[9]  = mk(0, 8'h00, 1, 1, 0, 1, 1, 0, 8'h00);
    tbl[10] = mk(0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h00);
    tbl[11] = mk(0, 8'h00, 1, 1, 0, 1, 1, 0, 8'h00);
    tbl[12] = mk(0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00);
    tbl[13] = mk(0, 8'h00, 0, 1, 0, 0, 0, 1, 8'h3C);
    tbl[14] = mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h3C);
    tbl[15] = mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h3C);
    tbl[16] = mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h3C);
    tbl[17] = mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h3C);
    tbl[18] = mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h3C);
    tbl[19] = mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h3C);

    // Idle link: nothing offered for 20 cycles.
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("idle c%0d mosi", k), 16'(MOSI), 16'h0);
      chk($sformatf("idle c%0d tx_ready", k), 16'(tx_ready), 16'h1);
      chk($sformatf("idle c%0d frame_start", k), 16'(tx_frame_start), 16'h0);
    end

    // Word offered exactly on the boundary edge goes out one frame later.
    do_reset();
    for (int i = 1; i <= 8; i++) step();
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    step();
    chk("bnd accept tx_ready", 16'(tx_ready), 16'h0);
    chk("bnd frame_start", 16'(tx_frame_start), 16'h0);
    tx_valid = 1'b0;
    w1 = '0;
    w2 = '0;
    fs_cnt = 0;
    for (int j = 0; j < 9; j++) begin
      step();
      w1[j] = MOSI;
      if (tx_frame_start) fs_cnt++;
    end
    chk("bnd frame_start at c18", 16'(tx_frame_start), 16'h1);
    for (int j = 0; j < 9; j++) begin
      step();
      w2[j] = MOSI;
      if (tx_frame_start) fs_cnt++;
    end
    chk("bnd idle frame", 16'(w1), 16'h000);
    chk("bnd data frame", 16'(w2), 16'h13C);
    chk("bnd frame_start count", 16'(fs_cnt), 16'h1);
    chk("bnd tx_ready after", 16'(tx_ready), 16'h1);

    // Full duplex: tx 0xA5 offered at cycle 2, rx 0x3C starting at bit_cnt 5.
    do_reset();
    slave_word = '0;
    for (int i = 0; i < 20; i++) begin
      tx_valid = tbl[i].tv;
      tx_data = tbl[i].td;
      MISO = tbl[i].miso;
      step();
      chk($sformatf("row%0d tx_ready", k), 16'(tx_ready), 16'(tbl[i].ready));
      chk($sformatf("row%0d frame_start", k), 16'(tx_frame_start), 16'(tbl[i].fs));
      chk($sformatf("row%0d mosi", k), 16'(MOSI), 16'(tbl[i].mosi));
      chk($sformatf("row%0d rx_busy", k), 16'(rx_busy), 16'(tbl[i].busy));
      chk($sformatf("row%0d rx_valid", k), 16'(rx_valid), 16'(tbl[i].rv));
      chk($sformatf("row%0d rx_data", k), 16'(rx_data), 16'(tbl[i].rd));
      if (k >= 10 && k <= 17) slave_word[k-10] = MOSI;
    end
    chk("slave word", 16'(slave_word), 16'h00A5);

    // Reset while a data frame is on the wire and rx is 4 bits into a word.
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    step();
    chk("rst seq accept", 16'(tx_ready), 16'h0);
    tx_valid = 1'b0;
    while (k < 24) step();
    MISO = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre-rst mosi", 16'(MOSI), 16'h1);
    chk("pre-rst rx_busy", 16'(rx_busy), 16'h1);
    chk("pre-rst rx_data", 16'(rx_data), 16'h3C);
    #3;
    rst = 1'b1;
    MISO = 1'b0;
    #1;
    check_reset_outputs("async rst");
    @(negedge SCLK);
    #1;
    rst = 1'b0;
    k = 0;
    for (int i = 1; i <= 18; i++) begin
      step();
      chk($sformatf("post-rst c%0d mosi", k), 16'(MOSI), 16'h0);
      chk($sformatf("post-rst c%0d rx_valid", k), 16'(rx_valid), 16'h0);
    end
    chk("post-rst tx_ready", 16'(tx_ready), 16'h1);
    MISO = 1'b1;
    step();
    w1 = 9'h081;
    for (int j = 0; j < 8; j++) begin
      MISO = w1[j];
      step();
      if (j < 7) begin
        chk($sformatf("post-rst rx bit%0d rx_valid", j), 16'(rx_valid), 16'h0);
        chk($sformatf("post-rst rx bit%0d rx_data", j), 16'(rx_data), 16'h0);
      end
    end
    MISO = 1'b0;
    chk("post-rst rx_valid", 16'(rx_valid), 16'h1);
    chk("post-rst rx_data", 16'(rx_data), 16'h81);
    step();
    chk("post-rst rx_valid drop", 16'(rx_valid), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_custom_master.md
Name: spi_custom_master

Overview:
Master end of the team's 3-wire custom SPI link (SCLK, MOSI, MISO), paired with the existing custom SPI slave.
- Tx: streams back-to-back frames of KEY_LENGTH+1 bits on MOSI, aligned to the slave's free-running frame counter.
- Rx: independently watches MISO for a slave-initiated start bit and deserialises KEY_LENGTH data bits.
- Sits on the untrusted-side host of the split-chip authentication path; it carries challenge/key words to and from the trusted IC.

Parameters:
KEY_LENGTH, 32, data bits per frame in each direction (frame length on MOSI is KEY_LENGTH+1 SCLK cycles)

Ports:
SCLK  input  1  serial clock, free-running; also routed to the slave; sole clock of this block
rst  input  1  reset, asynchronous, active-high
tx_data  input  KEY_LENGTH  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding register empty; tx_valid&&tx_ready at posedge = word accepted
tx_frame_start  output  1  one-cycle pulse: data frame just loaded for transmission
MOSI  output  1  serial data to slave
MISO  input  1  serial data from slave
rx_data  output  KEY_LENGTH  last word received
rx_valid  output  1  one-cycle pulse: rx_data updated
rx_busy  output  1  receive in progress (start bit seen, word incomplete)

Behaviour:
- Reset (async, rst=1): MOSI=0, tx_ready=1, tx_frame_start=0, rx_data=0, rx_valid=0, rx_busy=0. bit_cnt=0, holding reg empty, tx shift=0, rx FSM=IDLE. Slave must be reset in the same window; frame alignment restarts from the first SCLK posedge after release.
- bit_cnt: 0..KEY_LENGTH, +1 every posedge SCLK, wraps KEY_LENGTH->0. The posedge where bit_cnt==KEY_LENGTH is the frame boundary.
- Tx holding register (1 entry): tx_ready = !hold_full. Accept on posedge with tx_valid&&tx_ready.
- At the frame-boundary posedge:
  - hold_full: load tx shift with {1'b1, hold}, clear hold, pulse tx_frame_start for one cycle.
  - Else: load all zeros (idle frame).
- Same-cycle accept at the boundary with hold empty: the word goes into hold; the frame now starting is idle; the word is sent in the following frame. No bypass.
- MOSI is registered on negedge SCLK: MOSI <= shift[bit_cnt] for bit_cnt in 0..KEY_LENGTH. The slave samples on the next posedge.
- Frame on MOSI: bits 0..KEY_LENGTH-1 = data LSB first, then the marker bit (1=data frame, 0=idle).
- The first frame after reset is always idle (all zeros).
- Rx FSM (posedge SCLK, MISO sampled directly, no synchroniser):
  - IDLE: MISO==1 -> RECV, rx_cnt=0, rx_busy=1. MISO==0 -> stay.
  - RECV: rx_shift <= {MISO, rx_shift[KEY_LENGTH-1:1]}, rx_cnt+1. On the posedge sampling bit KEY_LENGTH-1: rx_data <= assembled word, rx_valid=1 for exactly one cycle, rx_busy=0, -> IDLE.
- The slave guarantees MISO=0 for at least one cycle after the last data bit, so back-to-back slave words are separated by that guard.
- The slave must hold its start bit across a posedge; a start bit shorter than that is not detected (protocol rule, not an error case here).
- Rx and Tx are fully independent: rx may start at any bit_cnt; a Tx boundary during RECV has no effect on rx.
- No rx backpressure. A new word overwrites rx_data; the consumer must capture it on rx_valid.
- Reset mid-frame or mid-RECV: everything returns to reset values immediately; partial words are discarded.

Test Plan:
1. KEY_LENGTH=8. Release reset, hold tx_valid=0 for 20 cycles -> MOSI constant 0, tx_ready=1, tx_frame_start never asserts.
2. KEY_LENGTH=8. Offer tx_data=0xA5 at cycle 2 -> tx_ready drops the next cycle; tx_frame_start pulses at the boundary posedge after cycle 8. Slave-side samples of MOSI over the second frame read 1,0,1,0,0,1,0,1, then marker 1. The slave reports 0xA5; tx_ready returns to 1.
3. KEY_LENGTH=8. Assert tx_valid with 0x3C exactly at the boundary cycle with hold empty -> that frame is idle (9 zeros); 0x3C appears in the next frame; one tx_frame_start pulse.
4. KEY_LENGTH=8. Drive MISO 1 (start), then 0,0,1,1,1,1,0,0, then 0 -> rx_busy high for 8 cycles; rx_valid single-cycle pulse at the 8th data posedge; rx_data=0x3C.
5. Full duplex: run scenarios 2 and 4 overlapped with the rx start at bit_cnt=5 -> slave receives 0xA5 and master rx_data=0x3C, with timing identical to the isolated runs.
6. Assert rst during RECV after 4 bits and during a data frame -> all outputs at reset values immediately. After release the first frame is idle and rx_valid stays 0 until a complete new word arrives.
